// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU results (port A, priority) and buffered load results (port B FIFO) into one regfile write per cycle.
// Latency: port A 1 cycle to wen; port B 2 cycles minimum (push, then issue from FIFO head).
// Backpressure: b_ready drops when the FIFO is full; a_ready drops for one cycle when the FIFO head has been starved STARVE_MAX times.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   port A handshake and payload (a_ready combinational)
//   b_valid/b_ready/b_addr/b_data   port B handshake and payload (b_ready combinational)
//   wen/waddr/wdata           registered regfile write port
//   chk1_addr/chk2_addr       decode read addresses to test against pending FIFO entries
//   chk1_busy/chk2_busy       combinational hazard flags (FIFO entries only)
// Optional feature: define WB_ZERO_REG_EN to make writes to register 0 consume their grant without asserting wen.
module regfile_wb_arbiter #(
    parameter int ASIZE      = 5,
    parameter int DSIZE      = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [ASIZE-1:0] a_addr,
    input  logic [DSIZE-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [ASIZE-1:0] b_addr,
    input  logic [DSIZE-1:0] b_data,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] chk1_addr,
    input  logic [ASIZE-1:0] chk2_addr,
    output logic             chk1_busy,
    output logic             chk2_busy
);

`ifdef WB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [ASIZE-1:0] fifo_addr [DEPTH];
    logic [DSIZE-1:0] fifo_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic fifo_nonempty;
    logic starve;
    logic grant_a;
    logic grant_b;
    logic push;
    logic a_write;
    logic b_write;

    assign fifo_nonempty = (count != '0);
    assign starve        = fifo_nonempty && (starve_cnt == SW'(STARVE_MAX));
    assign a_ready       = !rst && !starve;
    // Full means no accept, even if the head pops this cycle.
    assign b_ready       = !rst && (count < CW'(DEPTH));
    assign grant_a       = a_valid && a_ready;
    assign grant_b       = !rst && !grant_a && fifo_nonempty;
    assign push          = b_valid && b_ready;

    // A grant to register 0 is still consumed; it only suppresses wen.
    assign a_write = !ZERO_REG || (a_addr != '0);
    assign b_write = !ZERO_REG || (fifo_addr[rd_ptr] != '0);

    // Hazard lookup: slot i is live when its distance from rd_ptr is below count.
    // The head being popped this cycle is still live here, so it still reports busy.
    always_comb begin
        chk1_busy = 1'b0;
        chk2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr} < count) begin
                if (fifo_addr[i] == chk1_addr && (!ZERO_REG || chk1_addr != '0)) chk1_busy = 1'b1;
                if (fifo_addr[i] == chk2_addr && (!ZERO_REG || chk2_addr != '0)) chk2_busy = 1'b1;
            end
        end
    end

    // Storage needs no reset: liveness is tracked by rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (grant_b) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(grant_b);
            // Counts consecutive losses of a waiting head to port A.
            if (grant_b || !fifo_nonempty) begin
                starve_cnt <= '0;
            end else if (grant_a && starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (grant_a) begin
            wen <= a_write;
            if (a_write) begin
                waddr <= a_addr;
                wdata <= a_data;
            end
        end else if (grant_b) begin
            wen <= b_write;
            if (b_write) begin
                waddr <= fifo_addr[rd_ptr];
                wdata <= fifo_data[rd_ptr];
            end
        end else begin
            wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a queue-based reference model.
// Latency: checks combinational outputs 1 time unit after inputs change, registered outputs 1 unit after each posedge.
// Backpressure: producers hold valid/addr/data until the model reports the handshake completed.
module tb_regfile_wb_arbiter;
    localparam int ASIZE      = 5;
    localparam int DSIZE      = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

`ifdef WB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct {
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [ASIZE-1:0] a_addr = '0;
    logic [DSIZE-1:0] a_data = '0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [ASIZE-1:0] b_addr = '0;
    logic [DSIZE-1:0] b_data = '0;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE-1:0] chk1_addr = '0;
    logic [ASIZE-1:0] chk2_addr = '0;
    logic             chk1_busy;
    logic             chk2_busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
        .chk1_busy(chk1_busy), .chk2_busy(chk2_busy)
    );

    // Reference model: pending port-B results in arrival order, plus how many
    // times in a row the oldest one has lost to port A.
    ent_t             mq[$];
    int               m_losses = 0;
    logic             m_wen = 1'b0;
    logic [ASIZE-1:0] m_waddr = '0;
    logic [DSIZE-1:0] m_wdata = '0;
    bit               m_ga = 1'b0;
    bit               m_push = 1'b0;

    logic obs_a_ready;
    logic obs_b_ready;
    logic obs_busy1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [ASIZE-1:0] a);
        if (ZR && a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: check combinational outputs, advance model at the edge, check registered outputs.
    task automatic tick();
        int   n;
        bit   starving, ga, gb, push;
        ent_t e;
        #1;
        n        = mq.size();
        starving = (n != 0) && (m_losses >= STARVE_MAX);
        obs_a_ready = a_ready;
        obs_b_ready = b_ready;
        obs_busy1   = chk1_busy;
        chk_eq("a_ready",   a_ready,   64'(!rst && !starving));
        chk_eq("b_ready",   b_ready,   64'(!rst && (n < DEPTH)));
        chk_eq("chk1_busy", chk1_busy, 64'(m_busy(chk1_addr)));
        chk_eq("chk2_busy", chk2_busy, 64'(m_busy(chk2_addr)));
        ga   = !rst && a_valid && !starving;
        gb   = !rst && !ga && (n != 0);
        push = !rst && b_valid && (n < DEPTH);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_losses = 0;
            m_wen    = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            if (ga) begin
                m_wen = !(ZR && a_addr == '0);
                if (m_wen) begin
                    m_waddr = a_addr;
                    m_wdata = a_data;
                end
                if (n != 0) m_losses++;
            end else if (gb) begin
                e        = mq.pop_front();
                m_wen    = !(ZR && e.addr == '0);
                if (m_wen) begin
                    m_waddr = e.addr;
                    m_wdata = e.data;
                end
                m_losses = 0;
            end else begin
                m_wen = 1'b0;
            end
            if (n == 0) m_losses = 0;
            if (push) begin
                e.addr = b_addr;
                e.data = b_data;
                mq.push_back(e);
            end
        end
        m_ga   = ga;
        m_push = push;
        #1;
        chk_eq("wen",   wen,   64'(m_wen));
        chk_eq("waddr", waddr, 64'(m_waddr));
        chk_eq("wdata", wdata, 64'(m_wdata));
    endtask

    task automatic drain();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (DEPTH + 2) tick();
    endtask

    task automatic rand_drive();
        rst = ($urandom_range(0, 99) == 0);
        if (!(a_valid && !m_ga)) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_addr  = ASIZE'($urandom_range(0, 7));
            a_data  = $urandom;
        end
        if (!(b_valid && !m_push)) begin
            b_valid = ($urandom_range(0, 1) != 0);
            b_addr  = ASIZE'($urandom_range(0, 7));
            b_data  = $urandom;
        end
        chk1_addr = ASIZE'($urandom_range(0, 7));
        chk2_addr = ASIZE'($urandom_range(0, 7));
    endtask

    logic [4:0]       starve_seq;
    logic [ASIZE-1:0] prev_waddr;

    initial begin
        // Bring the DUT out of its unknown power-up state before any checks.
        @(posedge clk);
        #1;

        // Reset held with both producers valid.
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_addr = 5; b_addr = 6;
        repeat (2) begin
            tick();
            chk_eq("rst_a_ready", obs_a_ready, 0);
            chk_eq("rst_b_ready", obs_b_ready, 0);
            chk_eq("rst_wen", wen, 0);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk_eq("post_rst_b_ready", obs_b_ready, 1);

        // Port A alone.
        a_valid = 1'b1; a_addr = 3; a_data = 32'h11;
        tick();
        chk_eq("a_only_wen", wen, 1);
        chk_eq("a_only_waddr", waddr, 3);
        chk_eq("a_only_wdata", wdata, 32'h11);
        a_valid = 1'b0;
        tick();
        chk_eq("a_idle_wen", wen, 0);

        // Fill the FIFO while A keeps winning, then full-with-pop, then refill.
        drain();
        a_valid = 1'b1; a_addr = 9; b_valid = 1'b1; chk1_addr = 20;
        for (int k = 0; k < 4; k++) begin
            b_addr = ASIZE'(20 + k);
            b_data = DSIZE'(100 + k);
            a_data = $urandom;
            tick();
            chk_eq("fill_b_ready", obs_b_ready, 1);
        end
        a_valid = 1'b0; b_addr = 24; b_data = 104;
        tick();
        chk_eq("full_b_ready", obs_b_ready, 0);
        chk_eq("full_busy", obs_busy1, 1);
        chk_eq("full_pop_waddr", waddr, 20);
        chk_eq("full_pop_wdata", wdata, 100);
        tick();
        chk_eq("refill_b_ready", obs_b_ready, 1);
        b_valid = 1'b0; chk1_addr = 0;

        // Starvation: one pending B entry against continuous A traffic.
        drain();
        a_valid = 1'b1; a_addr = 9; b_valid = 1'b1; b_addr = 17; b_data = 77;
        tick();
        b_valid = 1'b0;
        starve_seq = 5'b10111;
        for (int k = 0; k < 5; k++) begin
            a_data = $urandom;
            tick();
            chk_eq("starve_a_ready", obs_a_ready, starve_seq[k]);
            if (k == 3) chk_eq("starve_b_waddr", waddr, 17);
        end

        // Register 0 write from port A.
        drain();
        prev_waddr = m_waddr;
        a_valid = 1'b1; a_addr = 0; a_data = 32'hFF;
        tick();
        chk_eq("zero_a_ready", obs_a_ready, 1);
        chk_eq("zero_wen", wen, ZR ? 0 : 1);
        chk_eq("zero_waddr", waddr, ZR ? 64'(prev_waddr) : 0);
        a_valid = 1'b0;

        // Random traffic against the model.
        repeat (3000) begin
            rand_drive();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
